alu_share_ctrl: RTL and testbench



---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_core.sv | 34 +++
 rtl/alu_share_ctrl.sv | 135 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the shared-ALU sequencer: control codes, FSM encoding,
// default widths and a small port-index helper.
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_CTLW  = 4;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: AND/OR/ADD/SUB/unsigned SLT; any other code
// yields result 0 with err set.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CTLW  = DEFAULT_CTLW
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CTLW-1:0]  ctl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (ctl)
      CTLW'(CTL_AND): result = a & b;
      CTLW'(CTL_OR):  result = a | b;
      CTLW'(CTL_ADD): result = a + b;
      CTLW'(CTL_SUB): result = a - b;
      CTLW'(CTL_SLT): result = WIDTH'(a < b);
      default: begin
        result = '0;
        err    = 1'b1;
      end
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Two-port round-robin arbiter and sequencer around a single shared ALU:
// accept -> execute -> respond, one operation in flight.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CTLW  = DEFAULT_CTLW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [CTLW-1:0]  req_ctl0,
  input  logic [CTLW-1:0]  req_ctl1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err
);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             gnt_q, gnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CTLW-1:0]  ctl_q, ctl_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;

  logic             gnt_sel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_err;

  alu_core #(
    .WIDTH (WIDTH),
    .CTLW  (CTLW)
  ) u_alu (
    .a      (a_q),
    .b      (b_q),
    .ctl    (ctl_q),
    .result (alu_result),
    .zero   (alu_zero),
    .err    (alu_err)
  );

  // With a single requester valid, req_valid[1] directly names it.
  always_comb begin
    gnt_sel = (req_valid == 2'b11) ? prio_q : req_valid[1];
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    gnt_d       = gnt_q;
    a_d         = a_q;
    b_d         = b_q;
    ctl_d       = ctl_q;
    result_d    = result_q;
    zero_d      = zero_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = port_onehot(gnt_sel);
          gnt_d     = gnt_sel;
          prio_d    = ~gnt_sel;
          a_d       = gnt_sel ? req_a1 : req_a0;
          b_d       = gnt_sel ? req_b1 : req_b0;
          ctl_d     = gnt_sel ? req_ctl1 : req_ctl0;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        result_d    = alu_result;
        zero_d      = alu_zero;
        err_d       = alu_err;
        rsp_valid_d = port_onehot(gnt_q);
        state_d     = RESP;
      end
      RESP: begin
        // Result registers are left untouched so they stay stable until the next op.
        if (rsp_ready[gnt_q]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = '0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      gnt_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      ctl_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      gnt_q       <= gnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctl_q       <= ctl_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: expected responses are queued at
// request acceptance and compared when the DUT raises rsp_valid.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] op_a [2];
  logic [31:0] op_b [2];
  logic [3:0]  op_c [2];
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;

  typedef struct {
    int          port;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  logic prio_m;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(32), .CTLW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a0     (op_a[0]),
    .req_a1     (op_a[1]),
    .req_b0     (op_b[0]),
    .req_b1     (op_b[1]),
    .req_ctl0   (op_c[0]),
    .req_ctl1   (op_c[1]),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  function automatic exp_t model(input int port, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] c);
    exp_t e;
    e.port = port;
    e.err  = 1'b0;
    case (c)
      4'h0: e.res = a & b;
      4'h1: e.res = a | b;
      4'h2: e.res = a + b;
      4'h6: e.res = a - b;
      4'h7: e.res = (a < b) ? 32'd1 : 32'd0;
      default: begin
        e.res = 32'd0;
        e.err = 1'b1;
      end
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  task automatic issue(input int port, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] c, input exp_t e);
    bit got = 0;
    @(negedge clk);
    op_a[port] = a;
    op_b[port] = b;
    op_c[port] = c;
    req_valid[port] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready != 2'b00) begin
        checks++;
        if (req_ready !== ((port == 1) ? 2'b10 : 2'b01)) begin
          failures++;
          $display("FAIL issue_req_ready got=%b exp=%b", req_ready, (port == 1) ? 2'b10 : 2'b01);
        end
        got = 1;
        sbq.push_back(e);
        prio_m = (port == 0);
        @(posedge clk);
        #1;
        req_valid[port] = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL issue_accept_timeout port=%0d got=no_accept exp=accept", port);
      req_valid[port] = 1'b0;
    end
  endtask

  task automatic collect(input int port, output int lat);
    bit   seen = 0;
    exp_t e;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      lat++;
      if (rsp_valid != 2'b00) begin
        seen = 1;
        break;
      end
    end
    if (!seen || sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL collect_timeout port=%0d got=seen%0d/q%0d exp=response", port, seen, sbq.size());
    end else begin
      e = sbq.pop_front();
      checks++;
      if (rsp_valid !== ((e.port == 1) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL rsp_valid got=%b exp_port=%0d", rsp_valid, e.port);
      end
      checks++;
      if (rsp_result !== e.res) begin
        failures++;
        $display("FAIL rsp_result got=%h exp=%h", rsp_result, e.res);
      end
      checks++;
      if (rsp_zero !== e.zero || rsp_err !== e.err) begin
        failures++;
        $display("FAIL rsp_flags got=z%b e%b exp=z%b e%b", rsp_zero, rsp_err, e.zero, e.err);
      end
      rsp_ready[port] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready[port] = 1'b0;
      checks++;
      if (rsp_valid !== 2'b00) begin
        failures++;
        $display("FAIL rsp_valid_after_hs got=%b exp=00", rsp_valid);
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL reset_handshake got=rr%b rv%b exp=00/00", req_ready, rsp_valid);
    end
    checks++;
    if (rsp_result !== 32'd0 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp got=%h z%b e%b exp=0 z0 e0", rsp_result, rsp_zero, rsp_err);
    end
    @(negedge clk);
    rst = 1'b0;
    prio_m = 1'b0;
  endtask

  task automatic test_single_ops;
    int lat;
    issue(0, 32'd5, 32'd3, CTL_ADD, exp_t'{0, 32'd8, 1'b0, 1'b0});
    collect(0, lat);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL latency got=%0d exp=2", lat);
    end
    issue(0, 32'd3, 32'd5, CTL_SUB, exp_t'{0, 32'hFFFF_FFFE, 1'b0, 1'b0});
    collect(0, lat);
    issue(0, 32'd3, 32'd5, CTL_SLT, exp_t'{0, 32'd1, 1'b0, 1'b0});
    collect(0, lat);
    issue(0, 32'd5, 32'd3, CTL_SLT, exp_t'{0, 32'd0, 1'b1, 1'b0});
    collect(0, lat);
  endtask

  task automatic test_zero_err;
    int lat;
    issue(0, 32'hF0, 32'h0F, CTL_AND, exp_t'{0, 32'd0, 1'b1, 1'b0});
    collect(0, lat);
    issue(1, 32'hF0, 32'h0F, CTL_OR, exp_t'{1, 32'hFF, 1'b0, 1'b0});
    collect(1, lat);
    issue(0, 32'h1234, 32'h77, 4'b0101, exp_t'{0, 32'd0, 1'b1, 1'b1});
    collect(0, lat);
  endtask

  task automatic test_wrap;
    int lat;
    issue(1, 32'hFFFF_FFFF, 32'd1, CTL_ADD, exp_t'{1, 32'd0, 1'b1, 1'b0});
    collect(1, lat);
  endtask

  // Both ports (or one) streaming with rsp_ready held high; checks grant
  // order against the round-robin pointer and 3-cycle accept spacing.
  task automatic run_stream(input int n0, input int n1);
    int         cnt [2];
    bit         refresh [2];
    int         resp = 0;
    int         last = -1;
    int         g;
    int         exp_g;
    bit         done = 0;
    exp_t       e;
    logic [3:0] codes [7];
    codes = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h5, 4'hF};
    cnt = '{0, 0};
    refresh = '{1, 1};
    rsp_ready = 2'b11;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (refresh[p]) begin
          op_a[p] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
          op_b[p] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
          op_c[p] = codes[$urandom_range(0, 6)];
          refresh[p] = 0;
        end
      end
      req_valid[0] = (cnt[0] < n0);
      req_valid[1] = (cnt[1] < n1);
      #1;
      if (rsp_valid != 2'b00) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL stream_unexpected_rsp got=%b exp=none", rsp_valid);
        end else begin
          e = sbq.pop_front();
          if (rsp_valid !== ((e.port == 1) ? 2'b10 : 2'b01) || rsp_result !== e.res ||
              rsp_zero !== e.zero || rsp_err !== e.err) begin
            failures++;
            $display("FAIL stream_rsp got=v%b %h z%b e%b exp=p%0d %h z%b e%b",
                     rsp_valid, rsp_result, rsp_zero, rsp_err, e.port, e.res, e.zero, e.err);
          end
          resp++;
        end
      end
      if (req_ready != 2'b00) begin
        g = req_ready[1] ? 1 : 0;
        exp_g = (req_valid == 2'b11) ? int'(prio_m) : (req_valid[1] ? 1 : 0);
        checks++;
        if (req_ready !== ((exp_g == 1) ? 2'b10 : 2'b01)) begin
          failures++;
          $display("FAIL stream_grant got=%b exp_port=%0d", req_ready, exp_g);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 3) begin
            failures++;
            $display("FAIL stream_spacing got=%0d exp=3", cyc - last);
          end
        end
        last = cyc;
        sbq.push_back(model(g, op_a[g], op_b[g], op_c[g]));
        prio_m = (g == 0);
        cnt[g]++;
        refresh[g] = 1;
      end
      if (cnt[0] == n0 && cnt[1] == n1 && resp == n0 + n1) begin
        done = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    rsp_ready = 2'b00;
    req_valid = 2'b00;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL stream_timeout got=%0d/%0d exp=%0d/%0d", cnt[0], cnt[1], n0, n1);
    end
  endtask

  task automatic test_arbitration;
    run_stream(4, 4);
  endtask

  task automatic test_port1_alone;
    int lat;
    issue(1, 32'd10, 32'd4, CTL_SUB, exp_t'{1, 32'd6, 1'b0, 1'b0});
    collect(1, lat);
    issue(1, 32'd10, 32'd4, CTL_ADD, exp_t'{1, 32'd14, 1'b0, 1'b0});
    collect(1, lat);
  endtask

  task automatic test_backpressure;
    int   lat;
    bit   seen = 0;
    exp_t e;
    issue(0, 32'd100, 32'd23, CTL_ADD, exp_t'{0, 32'd123, 1'b0, 1'b0});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid != 2'b00) begin
        seen = 1;
        break;
      end
    end
    op_a[1] = 32'd9;
    op_b[1] = 32'd9;
    op_c[1] = CTL_SUB;
    req_valid[1] = 1'b1;
    rsp_ready[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (!seen || rsp_valid !== 2'b01 || rsp_result !== 32'd123 || rsp_zero !== 1'b0 ||
          rsp_err !== 1'b0 || req_ready !== 2'b00) begin
        failures++;
        $display("FAIL bp_hold got=v%b %h z%b e%b rr%b exp=v01 0000007b z0 e0 rr00",
                 rsp_valid, rsp_result, rsp_zero, rsp_err, req_ready);
      end
    end
    if (sbq.size() > 0) e = sbq.pop_front();
    rsp_ready[1] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[0] = 1'b0;
    checks++;
    if (rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL bp_release got=%b exp=00", rsp_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      failures++;
      $display("FAIL bp_next_grant got=%b exp=10", req_ready);
    end
    sbq.push_back(exp_t'{1, 32'd0, 1'b1, 1'b0});
    prio_m = 1'b0;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    collect(1, lat);
  endtask

  task automatic test_back_to_back;
    run_stream(3, 0);
  endtask

  task automatic test_reset_mid_resp;
    int   lat;
    bit   seen = 0;
    exp_t e;
    issue(1, 32'd7, 32'd8, CTL_OR, exp_t'{1, 32'd15, 1'b0, 1'b0});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid != 2'b00) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL rst_mid_no_resp got=00 exp=10");
    end
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_result !== 32'd0 ||
        rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=rr%b rv%b %h z%b e%b exp=all0",
               req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err);
    end
    if (sbq.size() > 0) e = sbq.pop_front();
    @(negedge clk);
    rst = 1'b0;
    prio_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 2'b00) begin
        failures++;
        $display("FAIL rst_mid_stale_rsp got=%b exp=00", rsp_valid);
      end
    end
    issue(0, 32'd5, 32'd3, CTL_ADD, exp_t'{0, 32'd8, 1'b0, 1'b0});
    collect(0, lat);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL rst_mid_latency got=%0d exp=2", lat);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    prio_m = 1'b0;
    for (int p = 0; p < 2; p++) begin
      op_a[p] = '0;
      op_b[p] = '0;
      op_c[p] = '0;
    end
    test_reset;
    test_single_ops;
    test_zero_err;
    test_wrap;
    test_arbitration;
    test_port1_alone;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_resp;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
